// File: rtl/mem_alloc.sv
// mem_alloc: serialises fetch/load/store requests (store > load > fetch) into single-byte RAM/IO bus cycles
module mem_alloc #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter logic [1:0] IO_PREFIX = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_branch_in,
  input  logic              io_buffer_full_in,
  input  logic              if_to_alloc_en_in,
  input  logic [ADDR_W-1:0] if_a_in,
  output logic              alloc_to_if_gr_out,
  output logic              alloc_to_if_en_out,
  output logic [WORD_W-1:0] alloc_to_if_d_out,
  input  logic [ADDR_W-1:0] lsb_a_in,
  input  logic              lsb_to_alloc_r_en_in,
  input  logic [1:0]        lsb_r_offset_in,
  output logic              alloc_to_lsb_r_gr_out,
  output logic              alloc_to_lsb_r_en_out,
  output logic [WORD_W-1:0] alloc_to_lsb_d_out,
  input  logic              lsb_to_alloc_w_en_in,
  input  logic [1:0]        lsb_w_offset_in,
  input  logic [WORD_W-1:0] lsb_d_in,
  output logic              alloc_to_lsb_w_gr_out,
  output logic              alloc_to_lsb_w_en_out,
  input  logic [7:0]        mem_din_in,
  output logic [7:0]        mem_dout_out,
  output logic [ADDR_W-1:0] mem_a_out,
  output logic              mem_wr_out
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state;
  logic [1:0] cnt, ai, n, cnt_nx;
  logic primed, owner_lsb, st_ok;
  logic [WORD_W-1:0] asm_q, asm_nx;
  assign cnt_nx = cnt + 2'd1;
  assign st_ok = lsb_to_alloc_w_en_in && !(lsb_a_in[17:16] == IO_PREFIX && io_buffer_full_in);
  always_comb begin
    asm_nx = asm_q;
    asm_nx[{cnt, 3'b000} +: 8] = mem_din_in;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= IDLE;
      cnt <= '0;
      ai <= '0;
      n <= '0;
      primed <= 1'b0;
      owner_lsb <= 1'b0;
      asm_q <= '0;
      alloc_to_if_gr_out <= 1'b0;
      alloc_to_if_en_out <= 1'b0;
      alloc_to_if_d_out <= '0;
      alloc_to_lsb_r_gr_out <= 1'b0;
      alloc_to_lsb_r_en_out <= 1'b0;
      alloc_to_lsb_d_out <= '0;
      alloc_to_lsb_w_gr_out <= 1'b0;
      alloc_to_lsb_w_en_out <= 1'b0;
      mem_dout_out <= '0;
      mem_a_out <= '0;
      mem_wr_out <= 1'b0;
    end else if (rdy_in) begin
      alloc_to_if_gr_out <= 1'b0;
      alloc_to_if_en_out <= 1'b0;
      alloc_to_lsb_r_gr_out <= 1'b0;
      alloc_to_lsb_r_en_out <= 1'b0;
      alloc_to_lsb_w_gr_out <= 1'b0;
      alloc_to_lsb_w_en_out <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          ai <= '0;
          primed <= 1'b0;
          if (st_ok) begin
            state <= WRITE;
            owner_lsb <= 1'b1;
            n <= lsb_w_offset_in;
            mem_a_out <= lsb_a_in;
            mem_dout_out <= lsb_d_in[7:0];
            mem_wr_out <= 1'b1;
            asm_q <= lsb_d_in;
            alloc_to_lsb_w_gr_out <= 1'b1;
          end else if (!clear_branch_in && lsb_to_alloc_r_en_in) begin
            state <= READ;
            owner_lsb <= 1'b1;
            n <= lsb_r_offset_in;
            mem_a_out <= lsb_a_in;
            asm_q <= '0;
            alloc_to_lsb_r_gr_out <= 1'b1;
          end else if (!clear_branch_in && if_to_alloc_en_in) begin
            state <= READ;
            owner_lsb <= 1'b0;
            n <= 2'd3;
            mem_a_out <= if_a_in;
            asm_q <= '0;
            alloc_to_if_gr_out <= 1'b1;
          end
        end
        READ: begin
          if (clear_branch_in && !owner_lsb) begin
            state <= IDLE;
          end else begin
            if (ai != n) begin
              ai <= ai + 2'd1;
              mem_a_out <= mem_a_out + ADDR_W'(1);
            end
            primed <= 1'b1;
            if (primed) begin
              asm_q <= asm_nx;
              cnt <= cnt_nx;
              if (cnt == n) begin
                state <= IDLE;
                alloc_to_if_en_out <= !owner_lsb;
                alloc_to_lsb_r_en_out <= owner_lsb;
                if (owner_lsb) alloc_to_lsb_d_out <= asm_nx;
                else alloc_to_if_d_out <= asm_nx;
              end
            end
          end
        end
        WRITE: begin
          if (cnt == n) begin
            state <= IDLE;
            mem_wr_out <= 1'b0;
            alloc_to_lsb_w_en_out <= 1'b1;
          end else begin
            cnt <= cnt_nx;
            mem_a_out <= mem_a_out + ADDR_W'(1);
            mem_dout_out <= asm_q[{cnt_nx, 3'b000} +: 8];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_alloc.sv
// tb_mem_alloc: transaction-level reference model and per-cycle checks for mem_alloc
module tb_mem_alloc;
  logic clk_in = 0, rst_in = 0, rdy_in = 1, clear_branch_in = 0, io_buffer_full_in = 0;
  logic if_to_alloc_en_in = 0, lsb_to_alloc_r_en_in = 0, lsb_to_alloc_w_en_in = 0;
  logic [31:0] if_a_in = 0, lsb_a_in = 0, lsb_d_in = 0;
  logic [1:0] lsb_r_offset_in = 0, lsb_w_offset_in = 0;
  logic [7:0] mem_din_in = 0;
  logic alloc_to_if_gr_out, alloc_to_if_en_out, alloc_to_lsb_r_gr_out, alloc_to_lsb_r_en_out;
  logic alloc_to_lsb_w_gr_out, alloc_to_lsb_w_en_out, mem_wr_out;
  logic [31:0] alloc_to_if_d_out, alloc_to_lsb_d_out, mem_a_out;
  logic [7:0] mem_dout_out;
  mem_alloc dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_branch_in(clear_branch_in),
    .io_buffer_full_in(io_buffer_full_in), .if_to_alloc_en_in(if_to_alloc_en_in), .if_a_in(if_a_in),
    .alloc_to_if_gr_out(alloc_to_if_gr_out), .alloc_to_if_en_out(alloc_to_if_en_out),
    .alloc_to_if_d_out(alloc_to_if_d_out), .lsb_a_in(lsb_a_in), .lsb_to_alloc_r_en_in(lsb_to_alloc_r_en_in),
    .lsb_r_offset_in(lsb_r_offset_in), .alloc_to_lsb_r_gr_out(alloc_to_lsb_r_gr_out),
    .alloc_to_lsb_r_en_out(alloc_to_lsb_r_en_out), .alloc_to_lsb_d_out(alloc_to_lsb_d_out),
    .lsb_to_alloc_w_en_in(lsb_to_alloc_w_en_in), .lsb_w_offset_in(lsb_w_offset_in), .lsb_d_in(lsb_d_in),
    .alloc_to_lsb_w_gr_out(alloc_to_lsb_w_gr_out), .alloc_to_lsb_w_en_out(alloc_to_lsb_w_en_out),
    .mem_din_in(mem_din_in), .mem_dout_out(mem_dout_out), .mem_a_out(mem_a_out), .mem_wr_out(mem_wr_out)
  );
  always #5 clk_in = ~clk_in;
  logic [7:0] bus_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  int checks = 0, failures = 0;
  int cyc = 0;
  bit live = 0, rz = 0, rnd = 0;
  bit v = 0;
  int tk, tn, tT, tab, tfree;
  logic [31:0] ta, td, ba;
  int mT [3];
  int if_gr_at, r_gr_at, w_gr_at, if_en_at, r_en_at, w_en_at;
  int if_en_n = 0, w_en_n = 0, wr_n = 0, wr30_n = 0;
  logic [31:0] if_dv, lsb_dv;
  function automatic logic [7:0] dflt(logic [31:0] a);
    return a[7:0] * 8'd37 + a[15:8] + 8'h11;
  endfunction
  function automatic logic [7:0] rd_bus(logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] rd_ref(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] rand_addr();
    int r = $urandom % 8;
    return r == 0 ? 32'hFFFF_FFFE + ($urandom % 4) : r == 1 ? 32'h0003_0000 + ($urandom % 4) : 32'h1000 + ($urandom % 32);
  endfunction
  function automatic logic [1:0] pick_off();
    int r = $urandom % 3;
    return r == 0 ? 2'd0 : r == 1 ? 2'd1 : 2'd3;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask
  task automatic poke(logic [31:0] a, logic [7:0] b);
    bus_mem[a] = b;
    ref_mem[a] = b;
  endtask
  task automatic accept(int k, logic [31:0] a, int n, logic [31:0] d);
    v = 1; tk = k; ta = a; tn = n; td = d; tT = cyc; tab = -1;
    tfree = k == 2 ? cyc + 2 + n : cyc + 3 + n;
    mT[k] = cyc;
  endtask
  task automatic step();
    int j;
    bit win, eg_if, eg_r, eg_w, ed_if, ed_r, ed_w, ewr, adv;
    logic [31:0] exd;
    j = cyc - tT - 1;
    win = v && j >= 0 && j <= tn && (tab < 0 || cyc <= tab);
    eg_if = v && j == 0 && tk == 0;
    eg_r = v && j == 0 && tk == 1;
    eg_w = v && j == 0 && tk == 2;
    ewr = win && tk == 2;
    ed_if = v && tk == 0 && tab < 0 && j == tn + 2;
    ed_r = v && tk == 1 && j == tn + 2;
    ed_w = v && tk == 2 && j == tn + 1;
    if (live && rz) begin
      chk("rst_if_gr", 32'(alloc_to_if_gr_out), 0);
      chk("rst_if_en", 32'(alloc_to_if_en_out), 0);
      chk("rst_if_d", alloc_to_if_d_out, 0);
      chk("rst_r_gr", 32'(alloc_to_lsb_r_gr_out), 0);
      chk("rst_r_en", 32'(alloc_to_lsb_r_en_out), 0);
      chk("rst_lsb_d", alloc_to_lsb_d_out, 0);
      chk("rst_w_gr", 32'(alloc_to_lsb_w_gr_out), 0);
      chk("rst_w_en", 32'(alloc_to_lsb_w_en_out), 0);
      chk("rst_dout", 32'(mem_dout_out), 0);
      chk("rst_a", mem_a_out, 0);
      chk("rst_wr", 32'(mem_wr_out), 0);
    end else if (live) begin
      chk("if_gr", 32'(alloc_to_if_gr_out), 32'(eg_if));
      chk("r_gr", 32'(alloc_to_lsb_r_gr_out), 32'(eg_r));
      chk("w_gr", 32'(alloc_to_lsb_w_gr_out), 32'(eg_w));
      chk("if_en", 32'(alloc_to_if_en_out), 32'(ed_if));
      chk("r_en", 32'(alloc_to_lsb_r_en_out), 32'(ed_r));
      chk("w_en", 32'(alloc_to_lsb_w_en_out), 32'(ed_w));
      chk("mem_wr", 32'(mem_wr_out), 32'(ewr));
      if (win) chk("mem_a", mem_a_out, ta + 32'(j));
      if (ewr) begin
        chk("mem_dout", 32'(mem_dout_out), 32'(td[8*j +: 8]));
        ref_mem[ta + 32'(j)] = td[8*j +: 8];
      end
      if (ed_if || ed_r) begin
        exd = 0;
        for (int k = 0; k <= tn; k++) exd[8*k +: 8] = rd_ref(ta + 32'(k));
        if (ed_if) chk("if_d", alloc_to_if_d_out, exd);
        else chk("lsb_d", alloc_to_lsb_d_out, exd);
      end
    end
    if (alloc_to_if_gr_out) if_gr_at = cyc;
    if (alloc_to_lsb_r_gr_out) r_gr_at = cyc;
    if (alloc_to_lsb_w_gr_out) w_gr_at = cyc;
    if (alloc_to_if_en_out) begin if_en_at = cyc; if_en_n++; if_dv = alloc_to_if_d_out; end
    if (alloc_to_lsb_r_en_out) begin r_en_at = cyc; lsb_dv = alloc_to_lsb_d_out; end
    if (alloc_to_lsb_w_en_out) begin w_en_at = cyc; w_en_n++; end
    if (mem_wr_out) wr_n++;
    if (mem_wr_out && mem_a_out == 32'h0003_0000) wr30_n++;
    ba = mem_a_out;
    if (mem_wr_out) bus_mem[mem_a_out] = mem_dout_out;
    if (eg_if) if_to_alloc_en_in = 0;
    if (eg_r) lsb_to_alloc_r_en_in = 0;
    if (eg_w) lsb_to_alloc_w_en_in = 0;
    if (rnd) begin
      rdy_in = ($urandom % 8) != 0;
      clear_branch_in = ($urandom % 10) == 0;
      if (($urandom % 6) == 0) io_buffer_full_in = !io_buffer_full_in;
      if (!if_to_alloc_en_in && !eg_if && ($urandom % 3) == 0) begin
        if_to_alloc_en_in = 1;
        if_a_in = rand_addr();
      end
      if (!lsb_to_alloc_r_en_in && !lsb_to_alloc_w_en_in && !eg_r && !eg_w && ($urandom % 3) == 0) begin
        lsb_a_in = rand_addr();
        if ($urandom % 2) begin
          lsb_to_alloc_w_en_in = 1;
          lsb_w_offset_in = pick_off();
          lsb_d_in = $urandom;
        end else begin
          lsb_to_alloc_r_en_in = 1;
          lsb_r_offset_in = pick_off();
        end
      end
      rst_in = ($urandom % 300) != 0;
      if (!rst_in) begin
        rdy_in = 1;
        if_to_alloc_en_in = 0;
        lsb_to_alloc_r_en_in = 0;
        lsb_to_alloc_w_en_in = 0;
      end
    end
    adv = 0;
    if (!rst_in) begin
      v = 0; rz = 1; live = 1; adv = 1;
    end else if (rdy_in) begin
      adv = 1; rz = 0;
      if (v && tk == 0 && tab < 0 && clear_branch_in && cyc >= tT + 1 && cyc <= tT + 2 + tn) begin
        tab = cyc; tfree = cyc + 1;
      end
      if (!v || cyc >= tfree) begin
        if (lsb_to_alloc_w_en_in && !(lsb_a_in[17:16] == 2'b11 && io_buffer_full_in))
          accept(2, lsb_a_in, int'(lsb_w_offset_in), lsb_d_in);
        else if (lsb_to_alloc_r_en_in && !clear_branch_in) accept(1, lsb_a_in, int'(lsb_r_offset_in), 0);
        else if (if_to_alloc_en_in && !clear_branch_in) accept(0, if_a_in, 3, 0);
        else if (v && cyc >= tfree) v = 0;
      end
    end
    @(posedge clk_in);
    if (adv) cyc++;
    #1;
    if (adv) mem_din_in = rd_bus(ba);
    @(negedge clk_in);
  endtask
  task automatic steps(int k);
    for (int i = 0; i < k; i++) step();
  endtask
  initial begin
    int t, snap, snapw, rc;
    @(negedge clk_in);
    rst_in = 0;
    steps(2);
    rst_in = 1;
    step();
    poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'h10); poke(32'h1003, 8'h00);
    if_a_in = 32'h1000; if_to_alloc_en_in = 1;
    steps(10);
    chk("t1_data", if_dv, 32'h00100513);
    chk("t1_grant_lat", 32'(if_gr_at - mT[0]), 1);
    chk("t1_done_lat", 32'(if_en_at - mT[0]), 6);
    lsb_a_in = 32'h200; lsb_d_in = 32'hDEADBEEF; lsb_w_offset_in = 3; lsb_r_offset_in = 3;
    lsb_to_alloc_w_en_in = 1; lsb_to_alloc_r_en_in = 1; if_to_alloc_en_in = 1;
    steps(25);
    chk("t2_order_wr", 32'(w_gr_at < r_gr_at), 1);
    chk("t2_order_rf", 32'(r_gr_at < if_gr_at), 1);
    chk("t2_w_done_lat", 32'(w_en_at - mT[2]), 5);
    chk("t2_bytes", {rd_bus(32'h203), rd_bus(32'h202), rd_bus(32'h201), rd_bus(32'h200)}, 32'hDEADBEEF);
    chk("t2_load", lsb_dv, 32'hDEADBEEF);
    poke(32'h205, 8'hF0);
    lsb_a_in = 32'h205; lsb_r_offset_in = 0; lsb_to_alloc_r_en_in = 1;
    steps(6);
    chk("t3_lb", lsb_dv, 32'h000000F0);
    chk("t3_lat", 32'(r_en_at - mT[1]), 3);
    wr30_n = 0;
    io_buffer_full_in = 1;
    lsb_a_in = 32'h0003_0000; lsb_w_offset_in = 0; lsb_d_in = 32'hA5; lsb_to_alloc_w_en_in = 1;
    if_a_in = 32'h1000; if_to_alloc_en_in = 1;
    steps(5);
    io_buffer_full_in = 0;
    t = cyc;
    steps(15);
    chk("t4_fetch_first", 32'(if_gr_at < w_gr_at), 1);
    chk("t4_after_full", 32'(mT[2] >= t), 1);
    chk("t4_one_write", 32'(wr30_n), 1);
    if_a_in = 32'h1010; if_to_alloc_en_in = 1;
    snap = if_en_n;
    step(); step();
    clear_branch_in = 1; step(); clear_branch_in = 0;
    steps(10);
    chk("t5_fetch_aborted", 32'(if_en_n - snap), 0);
    lsb_a_in = 32'h1004; lsb_r_offset_in = 1; lsb_to_alloc_r_en_in = 1;
    step(); step();
    clear_branch_in = 1; step(); clear_branch_in = 0;
    steps(6);
    chk("t5_lh_done_lat", 32'(r_en_at - mT[1]), 4);
    lsb_a_in = 32'h240; lsb_d_in = 32'h11223344; lsb_w_offset_in = 3; lsb_to_alloc_w_en_in = 1;
    snapw = w_en_n;
    step(); step();
    rst_in = 0; rc = cyc; step(); rst_in = 1;
    snap = wr_n;
    steps(8);
    chk("t6_no_done", 32'(w_en_n - snapw), 0);
    chk("t6_no_write", 32'(wr_n - snap), 0);
    if_a_in = 32'h1000; if_to_alloc_en_in = 1;
    steps(8);
    chk("t6_idle_after", 32'(if_gr_at > rc), 1);
    rnd = 1;
    steps(6000);
    rnd = 0;
    rdy_in = 1; rst_in = 1; clear_branch_in = 0;
    if_to_alloc_en_in = 0; lsb_to_alloc_r_en_in = 0; lsb_to_alloc_w_en_in = 0;
    steps(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_alloc.md
Name: mem_alloc

Overview:
- Memory-port arbiter between the instruction fetch unit and the load/store buffer, and the byte-wide RAM/IO bus.
- Accepts word, halfword and byte requests and serialises them into single-byte bus cycles.
- Reassembles read data and returns it, or scatters write data onto the bus.
- Signals grant and completion back to the winning requester.

Parameters:
- ADDR_W, 32, address width
- WORD_W, 32, data word width
- IO_PREFIX, 2'b11, value of addr[17:16] that marks the memory-mapped IO region

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous, active-low reset
- rdy_in  in  1  global ready; low freezes the block
- clear_branch_in  in  1  mispredict flush
- io_buffer_full_in  in  1  IO output buffer full
- if_to_alloc_en_in  in  1  fetch read request (level)
- if_a_in  in  32  fetch address
- alloc_to_if_gr_out  out  1  fetch grant pulse
- alloc_to_if_en_out  out  1  fetch done pulse
- alloc_to_if_d_out  out  32  fetched word
- lsb_a_in  in  32  load/store address
- lsb_to_alloc_r_en_in  in  1  load request (level)
- lsb_r_offset_in  in  2  load byte count minus 1 (0, 1 or 3)
- alloc_to_lsb_r_gr_out  out  1  load grant pulse
- alloc_to_lsb_r_en_out  out  1  load done pulse
- alloc_to_lsb_d_out  out  32  load data, zero-extended
- lsb_to_alloc_w_en_in  in  1  store request (level)
- lsb_w_offset_in  in  2  store byte count minus 1
- lsb_d_in  in  32  store data
- alloc_to_lsb_w_gr_out  out  1  store grant pulse
- alloc_to_lsb_w_en_out  out  1  store done pulse
- mem_din_in  in  8  RAM read byte
- mem_dout_out  out  8  RAM write byte
- mem_a_out  out  32  RAM byte address
- mem_wr_out  out  1  RAM write strobe (1 = write)

Behaviour:
- All outputs are registered.
- Reset: when rst_in == 0 at a clock edge, state goes to IDLE and every output goes to 0, including mem_a_out and the data outputs.
- rdy_in == 0: all state and outputs hold.
- Bus model: mem_din_in in cycle c is the byte at the mem_a_out of cycle c-1. A write happens in any cycle with mem_wr_out = 1.
- States: IDLE, READ, WRITE. Registers: byte counter cnt (2 bits), last index n, owner (IF or LSB), 32-bit assembly register.
- Arbitration in IDLE at edge T, fixed priority: store, then load, then fetch.
  - A store to the IO region (addr[17:16] == IO_PREFIX) is not accepted while io_buffer_full_in = 1. A lower-priority request may be served instead.
- On acceptance at edge T:
  - The matching grant output is 1 for exactly cycle T+1.
  - mem_a_out = address, cnt = 0.
  - n = offset for LSB requests, n = 3 for fetch.
- Requesters drop their request on seeing the grant. Requests are not re-sampled until the block returns to IDLE.
- READ:
  - Addresses a+0 .. a+n are driven in cycles T+1 .. T+1+n, with mem_wr_out = 0.
  - Byte k is captured into bits [8k+7:8k].
  - The done pulse and the data are driven in cycle T+3+n. Unused upper bytes are 0; sign extension belongs to the LSB.
  - Return to IDLE; a new request can be accepted at the edge ending cycle T+3+n.
- WRITE:
  - Cycles T+1 .. T+1+n drive mem_a_out = a+k, mem_dout_out = lsb_d_in[8k+7:8k], mem_wr_out = 1.
  - Store data is latched at acceptance.
  - The done pulse is in cycle T+2+n, with mem_wr_out = 0; then IDLE.
- mem_wr_out is 0 in every cycle that is not a WRITE data cycle.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- IO gating is checked only at acceptance; a store accepted while the buffer is not full completes unconditionally.
- clear_branch_in = 1 (with rdy_in):
  - An in-flight fetch aborts: IDLE next cycle, alloc_to_if_en_out never pulses, any pending fetch grant pulse is cleared.
  - An in-flight load is not aborted and completes with its done pulse (the LSB discards it).
  - An in-flight store is never aborted.
  - Fetch and load requests are not accepted in the clear cycle; a store request may be.
- Reset asserted mid-transfer: abandon immediately; no done pulse; mem_wr_out = 0 next cycle.
- All done/grant outputs are one-cycle pulses, and at most one pulse of each kind is high per cycle.

Test Plan:
1. Fetch a = 0x1000, RAM bytes 0x13,0x05,0x10,0x00 -> grant in cycle T+1; mem_a_out 0x1000..0x1003; alloc_to_if_en_out in cycle T+6 with data 0x00100513.
2. Load, store and fetch requested in the same cycle (store SW a = 0x200, d = 0xDEADBEEF) -> store granted first: writes EF,BE,AD,DE to 0x200..0x203, done in T+5; then the load is granted; the fetch is last.
3. LB offset 0 at 0x205 with RAM byte 0xF0 -> alloc_to_lsb_d_out = 0x000000F0, done in T+3.
4. SB to 0x30000 with io_buffer_full_in = 1 for 5 cycles and a pending fetch -> fetch served; store accepted only after full drops; exactly one mem_wr_out cycle at 0x30000.
5. clear_branch_in during a fetch in its 2nd byte -> no alloc_to_if_en_out. clear_branch_in during an LH read -> alloc_to_lsb_r_en_out still pulses at T+4.
6. rst_in = 0 mid-SW after 2 bytes -> all outputs 0 next cycle; mem_wr_out stays 0; no done pulse; IDLE after reset releases.
